// File: rtl/decoder.sv
// Instruction decode stage: splits a 16-bit instruction into registered control
// signals and fields, giving one pipeline stage between fetch and execute.
module decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    output logic        MemoryWrite,
    output logic [2:0]  ExecuteOp,
    output logic [1:0]  WriteRegFrom,
    output logic        OverwriteNZ,
    output logic [3:0]  RegToWrite,
    output logic [7:0]  Immediate,
    output logic        RegWriteEnSc,
    output logic        RegWriteEnVec
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    typedef struct packed {
        logic       mem_wr;
        logic [2:0] exec_op;
        logic [1:0] wb_src;
        logic       set_nz;
        logic [3:0] rd;
        logic [7:0] imm;
        logic       we_sc;
        logic       we_vec;
    } dec_t;

    dec_t       dec_d, dec_q;
    logic [3:0] opcode;

    assign opcode = instruction[15:12];

    always_comb begin
        dec_d        = '0;
        // Register index and immediate are forwarded for every opcode.
        dec_d.rd     = instruction[11:8];
        dec_d.imm    = instruction[7:0];
        unique case (opcode)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                dec_d.exec_op = opcode[2:0] - 3'd1;
                dec_d.wb_src  = WB_ALU;
                dec_d.we_sc   = 1'b1;
                dec_d.set_nz  = 1'b1;
            end
            4'h8: begin
                dec_d.exec_op = OP_PASS;
                dec_d.wb_src  = WB_IMM;
                dec_d.we_sc   = 1'b1;
            end
            4'h9: begin
                dec_d.exec_op = OP_SUB;
                dec_d.set_nz  = 1'b1;
            end
            4'hA: begin
                dec_d.exec_op = OP_ADD;
                dec_d.wb_src  = WB_MEM;
                dec_d.we_sc   = 1'b1;
            end
            4'hB, 4'hF: begin
                dec_d.exec_op = OP_ADD;
                dec_d.mem_wr  = 1'b1;
            end
            4'hC: begin
                dec_d.exec_op = OP_ADD;
                dec_d.wb_src  = WB_ALU;
                dec_d.we_vec  = 1'b1;
            end
            4'hD: begin
                dec_d.exec_op = OP_SUB;
                dec_d.wb_src  = WB_ALU;
                dec_d.we_vec  = 1'b1;
            end
            4'hE: begin
                dec_d.exec_op = OP_ADD;
                dec_d.wb_src  = WB_MEM;
                dec_d.we_vec  = 1'b1;
            end
            default: ;
        endcase
    end

    // All-zero reset state is the NOP encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dec_q <= '0;
        else     dec_q <= dec_d;
    end

    assign MemoryWrite   = dec_q.mem_wr;
    assign ExecuteOp     = dec_q.exec_op;
    assign WriteRegFrom  = dec_q.wb_src;
    assign OverwriteNZ   = dec_q.set_nz;
    assign RegToWrite    = dec_q.rd;
    assign Immediate     = dec_q.imm;
    assign RegWriteEnSc  = dec_q.we_sc;
    assign RegWriteEnVec = dec_q.we_vec;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the decoder: hand-computed vectors, a full
// opcode sweep against a hand-written table, invariants and async reset.
module tb_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic        MemoryWrite;
    logic [2:0]  ExecuteOp;
    logic [1:0]  WriteRegFrom;
    logic        OverwriteNZ;
    logic [3:0]  RegToWrite;
    logic [7:0]  Immediate;
    logic        RegWriteEnSc;
    logic        RegWriteEnVec;

    int n_cmp = 0;
    int n_err = 0;

    decoder dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .MemoryWrite  (MemoryWrite),
        .ExecuteOp    (ExecuteOp),
        .WriteRegFrom (WriteRegFrom),
        .OverwriteNZ  (OverwriteNZ),
        .RegToWrite   (RegToWrite),
        .Immediate    (Immediate),
        .RegWriteEnSc (RegWriteEnSc),
        .RegWriteEnVec(RegWriteEnVec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control per opcode: {mem, op[2:0], wb[1:0], nz, sc, vec}
    logic [8:0] ctl_tbl [16];

    function automatic logic [20:0] bundle();
        return {MemoryWrite, ExecuteOp, WriteRegFrom, OverwriteNZ,
                RegToWrite, Immediate, RegWriteEnSc, RegWriteEnVec};
    endfunction

    function automatic logic [20:0] mk(input logic [8:0] ctl, input logic [3:0] rd,
                                       input logic [7:0] imm);
        return {ctl[8], ctl[7:5], ctl[4:3], ctl[2], rd, imm, ctl[1], ctl[0]};
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] ins);
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctl_tbl[0]  = 9'b0_000_00_0_0_0;
        ctl_tbl[1]  = 9'b0_000_00_1_1_0;
        ctl_tbl[2]  = 9'b0_001_00_1_1_0;
        ctl_tbl[3]  = 9'b0_010_00_1_1_0;
        ctl_tbl[4]  = 9'b0_011_00_1_1_0;
        ctl_tbl[5]  = 9'b0_100_00_1_1_0;
        ctl_tbl[6]  = 9'b0_101_00_1_1_0;
        ctl_tbl[7]  = 9'b0_110_00_1_1_0;
        ctl_tbl[8]  = 9'b0_111_10_0_1_0;
        ctl_tbl[9]  = 9'b0_001_00_1_0_0;
        ctl_tbl[10] = 9'b0_000_01_0_1_0;
        ctl_tbl[11] = 9'b1_000_00_0_0_0;
        ctl_tbl[12] = 9'b0_000_00_0_0_1;
        ctl_tbl[13] = 9'b0_001_00_0_0_1;
        ctl_tbl[14] = 9'b0_000_01_0_0_1;
        ctl_tbl[15] = 9'b1_000_00_0_0_0;

        // Reset held, instruction present, outputs must stay zero
        rst = 1'b1;
        instruction = 16'hF39D;
        #2;
        chk("reset_state", bundle(), 21'h0);
        @(posedge clk);
        #1;
        chk("reset_held_edge", bundle(), 21'h0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("vst_F39D", bundle(), {1'b1, 3'b000, 2'b00, 1'b0, 4'h3, 8'h9D, 1'b0, 1'b0});

        step(16'h5678);
        chk("xor_5678", bundle(), {1'b0, 3'b100, 2'b00, 1'b1, 4'h6, 8'h78, 1'b1, 1'b0});

        step(16'h8A42);
        chk("movi_8A42", bundle(), {1'b0, 3'b111, 2'b10, 1'b0, 4'hA, 8'h42, 1'b1, 1'b0});

        step(16'hE512);
        chk("vld_E512", bundle(), {1'b0, 3'b000, 2'b01, 1'b0, 4'h5, 8'h12, 1'b0, 1'b1});
        step(16'h9034);
        chk("cmp_9034", bundle(), {1'b0, 3'b001, 2'b00, 1'b1, 4'h0, 8'h34, 1'b0, 1'b0});

        // Sweep every opcode with random operand bits
        for (int op = 0; op < 16; op++) begin
            logic [11:0] lo;
            logic [15:0] ins;
            lo  = 12'($urandom_range(0, 4095));
            ins = {4'(op), lo};
            step(ins);
            chk($sformatf("sweep_op%0h", op), bundle(), mk(ctl_tbl[op], lo[11:8], lo[7:0]));
            chk($sformatf("inv_sc_vec_op%0h", op), 21'(RegWriteEnSc & RegWriteEnVec), 21'h0);
            chk($sformatf("inv_mem_we_op%0h", op),
                21'(MemoryWrite & (RegWriteEnSc | RegWriteEnVec)), 21'h0);
            chk($sformatf("inv_nz_op%0h", op), 21'(OverwriteNZ),
                21'((op >= 1 && op <= 7) || op == 9));
        end

        // Async reset pulse between two edges drops the decoded instruction
        step(16'h1ABC);
        chk("add_1ABC", bundle(), {1'b0, 3'b000, 2'b00, 1'b1, 4'hA, 8'hBC, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_clear", bundle(), 21'h0);
        #1;
        rst = 1'b0;
        instruction = 16'h0000;
        #1;
        chk("after_pulse_no_edge", bundle(), 21'h0);
        @(posedge clk);
        #1;
        chk("nop_0000", bundle(), 21'h0);

        step(16'hD7C3);
        chk("vsub_D7C3", bundle(), {1'b0, 3'b001, 2'b00, 1'b0, 4'h7, 8'hC3, 1'b0, 1'b1});
        step(16'h0FEE);
        chk("nop_0FEE", bundle(), {1'b0, 3'b000, 2'b00, 1'b0, 4'hF, 8'hEE, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
